// File: rtl/mult_hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: op encodings,
// FSM state type and default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MADDU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_CLR   = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD);
    endfunction

    function automatic logic is_acc_op(input logic [2:0] op);
        return (op == OP_MADDU) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/mult_hilo_if.sv
// Command/handshake bundle plus the link to the external array multiplier.
interface mult_hilo_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    modport master (
        output start, op, a, b, mul_hi, mul_lo,
        input  mul_a, mul_b, busy, done, hi_q, lo_q
    );

    modport slave (
        input  start, op, a, b, mul_hi, mul_lo,
        output mul_a, mul_b, busy, done, hi_q, lo_q
    );
endinterface

// File: rtl/mult_hilo_acc.sv
// Combinational HI/LO update: optional two's-complement negate of the raw
// product followed by an optional modulo-2^(2*WIDTH) accumulate.
module hilo_acc #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] p_raw,
    input  logic               neg,
    input  logic               acc,
    input  logic [2*WIDTH-1:0] hilo_q,
    output logic [2*WIDTH-1:0] hilo_nxt
);
    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] p_s;

    // Sign-correct the product, then overwrite or accumulate (carry-out dropped).
    always_comb begin
        p_s      = p_raw;
        hilo_nxt = p_raw;
        if (neg) begin
            p_s = ~p_raw + ONE;
        end else begin
            p_s = p_raw;
        end
        if (acc) begin
            hilo_nxt = hilo_q + p_s;
        end else begin
            hilo_nxt = p_s;
        end
    end
endmodule

// File: rtl/mult_hilo.sv
// HI/LO controller: latches operand magnitudes for the external array,
// waits a settle window, then captures the sign-corrected product.
module mult_hilo
    import mult_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input logic       clk,
    input logic       rst_n,
    mult_hilo_if.slave bus
);
    localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e             state_r;
    state_e             state_nxt_s;
    logic [3:0]         cnt_r;
    logic               neg_r;
    logic               acc_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               accept_mul_s;
    logic               accept_mov_s;
    logic               capture_s;
    logic [2*WIDTH-1:0] hilo_nxt_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE_W) : v;
    endfunction

    hilo_acc #(.WIDTH(WIDTH)) u_acc (
        .p_raw    ({bus.mul_hi, bus.mul_lo}),
        .neg      (neg_r),
        .acc      (acc_r),
        .hilo_q   ({hi_r, lo_r}),
        .hilo_nxt (hilo_nxt_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and command decode; moves complete without leaving IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        accept_mul_s = 1'b0;
        accept_mov_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && (bus.op <= OP_MADD)) begin
                    accept_mul_s = 1'b1;
                    state_nxt_s  = RUN;
                end else if (bus.start && (bus.op != OP_RSVD)) begin
                    accept_mov_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand latch, settle counter, HI/LO update and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 4'd0;
            neg_r   <= 1'b0;
            acc_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mul_a_r <= '0;
            mul_b_r <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept_mul_s) begin
                mul_a_r <= is_signed_op(bus.op) ? mag(bus.a) : bus.a;
                mul_b_r <= is_signed_op(bus.op) ? mag(bus.b) : bus.b;
                neg_r   <= is_signed_op(bus.op) & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc_r   <= is_acc_op(bus.op);
                cnt_r   <= 4'd0;
                busy_r  <= 1'b1;
            end else if (capture_s) begin
                {hi_r, lo_r} <= hilo_nxt_s;
                cnt_r        <= 4'd0;
                busy_r       <= 1'b0;
                done_r       <= 1'b1;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + 4'd1;
            end else if (accept_mov_s) begin
                case (bus.op)
                    OP_MTHI: hi_r <= bus.a;
                    OP_MTLO: lo_r <= bus.a;
                    OP_CLR: begin
                        hi_r <= '0;
                        lo_r <= '0;
                    end
                    default: begin
                        hi_r <= hi_r;
                    end
                endcase
                done_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.mul_a = mul_a_r;
    assign bus.mul_b = mul_b_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi_q  = hi_r;
    assign bus.lo_q  = lo_r;
endmodule

// File: tb/tb_mult_hilo.sv
// Directed bench for mult_hilo; the bench plays the external array multiplier.
module tb_mult_hilo;
    import mult_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] prod;
    int          n_vec;
    int          n_err;

    mult_hilo_if #(.WIDTH(16)) bus ();

    assign prod       = 32'(bus.mul_a) * 32'(bus.mul_b);
    assign bus.mul_hi = prod[31:16];
    assign bus.mul_lo = prod[15:0];

    mult_hilo #(.WIDTH(16), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done and busy must never be high together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_vec++;
            if (bus.done === 1'b1 && bus.busy === 1'b1) begin
                n_err++;
                $display("FAIL done_busy_overlap got done=%b busy=%b want not both 1", bus.done, bus.busy);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'h5A5A;
        bus.b     = 16'hA5A5;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({bus.mul_a, bus.mul_b, bus.hi_q, bus.lo_q, bus.busy, bus.done} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_outputs got a=%h b=%h hi=%h lo=%h busy=%b done=%b want all 0",
                     bus.mul_a, bus.mul_b, bus.hi_q, bus.lo_q, bus.busy, bus.done);
        end
    endtask

    task automatic test_multu();
        int cyc, bcnt;
        issue(OP_MULTU, 16'hFFFF, 16'hFFFF);
        wait_done(cyc, bcnt);
        n_vec++;
        if (cyc != 2) begin n_err++; $display("FAIL multu_latency got %0d want 2", cyc); end
        n_vec++;
        if (bcnt != 2) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 2", bcnt); end
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'hFFFE_0001) begin
            n_err++; $display("FAIL multu_result got %h want fffe0001", {bus.hi_q, bus.lo_q});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_mult_signed();
        int cyc, bcnt;
        issue(OP_MULT, 16'hFFFD, 16'h0005);
        n_vec++;
        if ({bus.mul_a, bus.mul_b} !== 32'h0003_0005) begin
            n_err++; $display("FAIL mult_magnitudes got %h want 00030005", {bus.mul_a, bus.mul_b});
        end
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'hFFFF_FFF1) begin
            n_err++; $display("FAIL mult_neg15 got %h want fffffff1", {bus.hi_q, bus.lo_q});
        end
        issue(OP_MULT, 16'h8000, 16'h8000);
        n_vec++;
        if ({bus.mul_a, bus.mul_b} !== 32'h8000_8000) begin
            n_err++; $display("FAIL mult_min_mag got %h want 80008000", {bus.mul_a, bus.mul_b});
        end
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h4000_0000) begin
            n_err++; $display("FAIL mult_min_sq got %h want 40000000", {bus.hi_q, bus.lo_q});
        end
    endtask

    task automatic test_accumulate();
        int cyc, bcnt;
        issue(OP_MTHI, 16'hFFFF, 16'h0000);
        n_vec++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi_q !== 16'hFFFF) begin
            n_err++; $display("FAIL mthi got done=%b busy=%b hi=%h want 1 0 ffff", bus.done, bus.busy, bus.hi_q);
        end
        issue(OP_MTLO, 16'hFFFF, 16'h0000);
        n_vec++;
        if (bus.done !== 1'b1 || bus.lo_q !== 16'hFFFF || bus.hi_q !== 16'hFFFF) begin
            n_err++; $display("FAIL mtlo got done=%b hi=%h lo=%h want 1 ffff ffff", bus.done, bus.hi_q, bus.lo_q);
        end
        issue(OP_MADDU, 16'h0001, 16'h0001);
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h0000_0000) begin
            n_err++; $display("FAIL maddu_wrap got %h want 00000000", {bus.hi_q, bus.lo_q});
        end
        issue(OP_MTLO, 16'h1234, 16'h0000);
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MADD, 16'hFFFF, 16'h0001);
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL madd_neg1 got %h want ffffffff", {bus.hi_q, bus.lo_q});
        end
        issue(OP_MADD, 16'hFFFE, 16'hFFFD);
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h0000_0005) begin
            n_err++; $display("FAIL madd_pos got %h want 00000005", {bus.hi_q, bus.lo_q});
        end
    endtask

    task automatic test_busy_ignore();
        int dones;
        issue(OP_MULTU, 16'h0007, 16'h0007);
        dones = 0;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 16'h0002;
        bus.b     = 16'h0003;
        for (int i = 0; i < 7; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        n_vec++;
        if (dones != 1) begin n_err++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h0000_0031) begin
            n_err++; $display("FAIL busy_ignore_result got %h want 00000031", {bus.hi_q, bus.lo_q});
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        issue(OP_MULTU, 16'h0007, 16'h0007);
        wait_done(cyc, bcnt);
        issue(OP_MULTU, 16'h0002, 16'h0003);
        n_vec++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h0000_0006 || cyc != 2) begin
            n_err++; $display("FAIL b2b_result got %h lat %0d want 00000006 lat 2", {bus.hi_q, bus.lo_q}, cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones, cyc, bcnt;
        issue(OP_MULTU, 16'h0005, 16'h0005);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.mul_a, bus.mul_b, bus.hi_q, bus.lo_q, bus.busy, bus.done} !== 66'd0) begin
            n_err++;
            $display("FAIL async_reset got a=%h b=%h hi=%h lo=%h busy=%b done=%b want all 0",
                     bus.mul_a, bus.mul_b, bus.hi_q, bus.lo_q, bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (dones != 0 || bus.lo_q !== 16'h0000) begin
            n_err++; $display("FAIL reset_lost_result got dones=%0d lo=%h want 0 0000", dones, bus.lo_q);
        end
        issue(OP_MULTU, 16'h0004, 16'h0004);
        wait_done(cyc, bcnt);
        n_vec++;
        if ({bus.hi_q, bus.lo_q} !== 32'h0000_0010) begin
            n_err++; $display("FAIL post_reset_mul got %h want 00000010", {bus.hi_q, bus.lo_q});
        end
    endtask

    task automatic test_reserved_and_clr();
        int dones, busies;
        issue(OP_RSVD, 16'hABCD, 16'h1234);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (dones != 0 || {bus.hi_q, bus.lo_q} !== 32'h0000_0010) begin
            n_err++; $display("FAIL reserved_op got events=%0d hilo=%h want 0 00000010", dones, {bus.hi_q, bus.lo_q});
        end
        issue(OP_MTHI, 16'h1234, 16'h0000);
        busies = 0;
        issue(OP_CLR, 16'hFFFF, 16'hFFFF);
        n_vec++;
        if (bus.done !== 1'b1 || {bus.hi_q, bus.lo_q} !== 32'h0000_0000) begin
            n_err++; $display("FAIL clr got done=%b hilo=%h want 1 00000000", bus.done, {bus.hi_q, bus.lo_q});
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.busy === 1'b1) busies++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (busies != 0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL clr_no_busy got busy_cycles=%0d done=%b want 0 0", busies, bus.done);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_multu();
        test_mult_signed();
        test_accumulate();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_reserved_and_clr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
